// File: rtl/vga_timing_pattern_gen.sv
// VGA timing generator with programmable porch/sync timing and a four-pattern test source.
// Pattern selection and solid colour are latched on frame boundaries so a switch never tears a frame.
module vga_timing_pattern_gen #(
  parameter int COLOR_W  = 4,
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 56,
  parameter int H_SYNC   = 120,
  parameter int H_BP     = 64,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 37,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 23,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int CHK_LOG2 = 5,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW      = $clog2(H_TOTAL),
  localparam int VW      = $clog2(V_TOTAL)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [1:0]             mode,
  input  logic [3*COLOR_W-1:0]   solid_rgb,
  output logic                   pix_ce,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   de,
  output logic [COLOR_W-1:0]     red,
  output logic [COLOR_W-1:0]     green,
  output logic [COLOR_W-1:0]     blue,
  output logic [HW-1:0]          hcount,
  output logic [VW-1:0]          vcount,
  output logic                   frame_start
);

  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_ONE  = DW'(1);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ONE    = HW'(1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ONE    = VW'(1);

  if (CLK_DIV < 1 || COLOR_W < 1 || H_ACTIVE < 1 || H_SYNC < 1 || V_ACTIVE < 1 || V_SYNC < 1 ||
      H_FP < 0 || H_BP < 0 || V_FP < 0 || V_BP < 0 || CHK_LOG2 < 0 || CHK_LOG2 > 31) begin : g_param_check
    $fatal(1, "vga_timing_pattern_gen: timing parameters out of range");
  end

  logic [1:0]           rst_sync;
  logic                 rst_int;
  logic [DW-1:0]        div;
  logic [HW-1:0]        h;
  logic [VW-1:0]        v;
  logic [1:0]           mode_l;
  logic [3*COLOR_W-1:0] solid_l;
  logic [31:0]          hx;
  logic [31:0]          vx;
  logic                 de_c;
  logic                 hs_c;
  logic                 vs_c;
  logic [2:0]           bar_c;
  logic [2:0]           mask_c;
  logic [3*COLOR_W-1:0] rgb_c;

  // Reset asserts asynchronously and releases two clocks later, in step with clk.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_int = rst_sync[1];

  // Pixel clock-enable divider; keeps running while en is low.
  always_ff @(posedge clk or negedge rst_int) begin
    if (!rst_int) begin
      div    <= '0;
      pix_ce <= 1'b0;
    end else begin
      if (div == DIV_LAST) begin
        div <= '0;
      end else begin
        div <= div + DIV_ONE;
      end
      pix_ce <= (div == DIV_LAST);
    end
  end

  assign hx = 32'(h);
  assign vx = 32'(v);

  // Decode of the current counter pair; registered below so outputs trail the counters by one pixel.
  always_comb begin
    de_c   = (hx < 32'(H_ACTIVE)) && (vx < 32'(V_ACTIVE));
    hs_c   = (hx >= 32'(HS_START)) && (hx < 32'(HS_END));
    vs_c   = (vx >= 32'(VS_START)) && (vx < 32'(VS_END));
    bar_c  = 3'd0;
    mask_c = 3'b000;
    for (int k = 1; k < 8; k++) begin
      if (hx >= 32'((H_ACTIVE * k) / 8)) begin
        bar_c = 3'(k);
      end else begin
        bar_c = bar_c;
      end
    end
    case (mode_l)
      2'd0: begin
        if (vx < 32'(V_ACTIVE / 2)) begin
          mask_c = (hx < 32'(H_ACTIVE / 2)) ? 3'b010 : 3'b001;
        end else begin
          mask_c = (hx < 32'(H_ACTIVE / 2)) ? 3'b100 : 3'b111;
        end
      end
      2'd1: begin
        case (bar_c)
          3'd0:    mask_c = 3'b111;
          3'd1:    mask_c = 3'b110;
          3'd2:    mask_c = 3'b011;
          3'd3:    mask_c = 3'b010;
          3'd4:    mask_c = 3'b101;
          3'd5:    mask_c = 3'b100;
          3'd6:    mask_c = 3'b001;
          default: mask_c = 3'b000;
        endcase
      end
      // The square containing (0,0) is white.
      2'd2:    mask_c = (hx[CHK_LOG2] ~^ vx[CHK_LOG2]) ? 3'b111 : 3'b000;
      default: mask_c = 3'b000;
    endcase
    if (!de_c) begin
      rgb_c = '0;
    end else if (mode_l == 2'd3) begin
      rgb_c = solid_l;
    end else begin
      rgb_c = {{COLOR_W{mask_c[2]}}, {COLOR_W{mask_c[1]}}, {COLOR_W{mask_c[0]}}};
    end
  end

  // Raster counters, frame latch and registered video outputs.
  always_ff @(posedge clk or negedge rst_int) begin
    if (!rst_int) begin
      h           <= '0;
      v           <= '0;
      mode_l      <= 2'd0;
      solid_l     <= '0;
      hcount      <= '0;
      vcount      <= '0;
      de          <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      frame_start <= 1'b0;
    end else if (!en) begin
      // Held idle at (0,0); tracking the inputs gives a fresh latch when en returns.
      h           <= '0;
      v           <= '0;
      mode_l      <= mode;
      solid_l     <= solid_rgb;
      hcount      <= '0;
      vcount      <= '0;
      de          <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      frame_start <= 1'b0;
    end else if (pix_ce) begin
      hcount              <= h;
      vcount              <= v;
      de                  <= de_c;
      hsync               <= hs_c ~^ HS_POL;
      vsync               <= vs_c ~^ VS_POL;
      {red, green, blue}  <= rgb_c;
      frame_start         <= (h == '0) && (v == '0);
      if (h == H_LAST) begin
        h <= '0;
        if (v == V_LAST) begin
          v       <= '0;
          mode_l  <= mode;
          solid_l <= solid_rgb;
        end else begin
          v <= v + V_ONE;
        end
      end else begin
        h <= h + H_ONE;
      end
    end else begin
      frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_pattern_gen.sv
// Scoreboard bench for vga_timing_pattern_gen on a scaled-down raster (23x12 totals, 16x8 active).
// Expected pixels are queued by raster index; a monitor pops and compares on every pixel step.
module tb_vga_timing_pattern_gen;

  localparam int CW    = 4;
  localparam int HT    = 23;
  localparam int VT    = 12;
  localparam int FRAME = HT * VT;
  localparam int HW    = $clog2(HT);
  localparam int VW    = $clog2(VT);
  localparam logic [31:0] IDLE_VEC = {8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000};

  typedef struct {
    int          idx;
    logic [31:0] vec;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b1;
  logic [1:0]    mode = 2'd1;
  logic [11:0]   solid_rgb = 12'h5A3;
  logic          pix_ce;
  logic          hsync;
  logic          vsync;
  logic          de;
  logic [CW-1:0] red;
  logic [CW-1:0] green;
  logic [CW-1:0] blue;
  logic [HW-1:0] hcount;
  logic [VW-1:0] vcount;
  logic          frame_start;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   step = 0;

  vga_timing_pattern_gen #(
    .COLOR_W(CW), .CLK_DIV(2),
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b1), .CHK_LOG2(2)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .solid_rgb(solid_rgb),
    .pix_ce(pix_ce), .hsync(hsync), .vsync(vsync), .de(de),
    .red(red), .green(green), .blue(blue),
    .hcount(hcount), .vcount(vcount), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] actual_vec();
    return {8'(hcount), 8'(vcount), de, hsync, vsync, frame_start, red, green, blue};
  endfunction

  task automatic push(input int f, input int x, input int y, input logic e_de, input logic e_hs,
                      input logic e_vs, input logic e_fs, input logic [11:0] e_rgb);
    exp_t e;
    e.idx = f * FRAME + y * HT + x;
    e.vec = {8'(x), 8'(y), e_de, e_hs, e_vs, e_fs, e_rgb};
    exp_q.push_back(e);
  endtask

  // Monitor: one pixel step per clock edge that sees pix_ce with en high.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (!rst || !en) begin
        step = 0;
      end else if (pix_ce) begin
        #1;
        while (exp_q.size() > 0 && exp_q[0].idx < step) begin
          e = exp_q.pop_front();
          n_cmp++;
          n_err++;
          $display("FAIL px_missed idx=%0d actual=step %0d required=step %0d", e.idx, step, e.idx);
        end
        if (exp_q.size() > 0 && exp_q[0].idx == step) begin
          e = exp_q.pop_front();
          n_cmp++;
          if (actual_vec() !== e.vec) begin
            n_err++;
            $display("FAIL px idx=%0d actual=%h required=%h", e.idx, actual_vec(), e.vec);
          end
        end
        step++;
      end
    end
  end

  task automatic wait_step(input int target);
    int n = 0;
    while (step < target && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (step < target) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_step actual=%0d required=%0d", step, target);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain actual=%0d left required=0 left", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_idle(input string name, input bit chk_pce);
    n_cmp++;
    if (actual_vec() !== IDLE_VEC) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", name, actual_vec(), IDLE_VEC);
    end
    if (chk_pce) begin
      n_cmp++;
      if (pix_ce !== 1'b0) begin
        n_err++;
        $display("FAIL %s_pix_ce actual=%b required=0", name, pix_ce);
      end
    end
  endtask

  initial begin
    #1 rst = 1'b0;
    // Frame 0: reset latch gives quad blocks even though mode input is 1.
    push(0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b1, 12'h0F0);
    push(0, 7, 0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h0F0);
    push(0, 8, 0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h00F);
    push(0, 16, 0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000);
    push(0, 17, 2, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000);
    push(0, 18, 2, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
    push(0, 20, 2, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
    push(0, 21, 2, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000);
    push(0, 0, 4, 1'b1, 1'b1, 1'b0, 1'b0, 12'hF00);
    push(0, 8, 5, 1'b1, 1'b1, 1'b0, 1'b0, 12'hFFF);
    push(0, 15, 7, 1'b1, 1'b1, 1'b0, 1'b0, 12'hFFF);
    push(0, 3, 8, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000);
    push(0, 3, 9, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000);
    push(0, 19, 10, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000);
    push(0, 0, 11, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000);
    push(0, 22, 11, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000);
    repeat (3) @(negedge clk);
    #2;
    check_idle("reset_hold", 1'b1);
    @(negedge clk);
    rst = 1'b1;

    // Mid-frame switch to solid: frame 0 stays quad, frame 1 is solid 5A3.
    wait_step(3 * HT);
    mode = 2'd3;
    push(1, 0, 0, 1'b1, 1'b1, 1'b0, 1'b1, 12'h5A3);
    push(1, 9, 2, 1'b1, 1'b1, 1'b0, 1'b0, 12'h5A3);
    push(1, 16, 3, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000);
    push(1, 9, 5, 1'b1, 1'b1, 1'b0, 1'b0, 12'h5A3);
    push(1, 15, 7, 1'b1, 1'b1, 1'b0, 1'b0, 12'h5A3);

    // Colour change mid-frame 1 must not show; frame 2 is colour bars.
    wait_step(FRAME + 3 * HT);
    mode = 2'd1;
    solid_rgb = 12'hFFF;
    push(2, 1, 0, 1'b1, 1'b1, 1'b0, 1'b1 & 1'b0, 12'hFFF);
    push(2, 2, 0, 1'b1, 1'b1, 1'b0, 1'b0, 12'hFF0);
    push(2, 5, 1, 1'b1, 1'b1, 1'b0, 1'b0, 12'h0FF);
    push(2, 6, 1, 1'b1, 1'b1, 1'b0, 1'b0, 12'h0F0);
    push(2, 9, 3, 1'b1, 1'b1, 1'b0, 1'b0, 12'hF0F);
    push(2, 10, 3, 1'b1, 1'b1, 1'b0, 1'b0, 12'hF00);
    push(2, 12, 6, 1'b1, 1'b1, 1'b0, 1'b0, 12'h00F);
    push(2, 14, 7, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000);
    push(2, 15, 7, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000);

    // Frame 3: checkerboard with 4-pixel squares.
    wait_step(2 * FRAME + 3 * HT);
    mode = 2'd2;
    push(3, 3, 0, 1'b1, 1'b1, 1'b0, 1'b0, 12'hFFF);
    push(3, 4, 0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000);
    push(3, 8, 0, 1'b1, 1'b1, 1'b0, 1'b0, 12'hFFF);
    push(3, 0, 4, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000);
    push(3, 4, 4, 1'b1, 1'b1, 1'b0, 1'b0, 12'hFFF);

    // Drop en while hsync is active, then restart with a fresh latch.
    wait_step(3 * FRAME + HT + 20);
    drain();
    en = 1'b0;
    @(posedge clk);
    #1;
    check_idle("en_low", 1'b0);
    @(negedge clk);
    mode = 2'd3;
    solid_rgb = 12'h123;
    repeat (3) @(negedge clk);
    check_idle("en_hold", 1'b0);
    push(0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b1, 12'h123);
    push(0, 1, 0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h123);
    push(0, 16, 0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000);
    en = 1'b1;

    // Asynchronous reset mid-line, then synchronised release.
    wait_step(2 * HT + 11);
    drain();
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_idle("async_reset", 1'b1);
    push(0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b1, 12'h0F0);
    push(0, 8, 4, 1'b1, 1'b1, 1'b0, 1'b0, 12'hFFF);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (pix_ce !== (k == 4)) begin
        n_err++;
        $display("FAIL pix_ce_after_release clk=%0d actual=%b required=%b", k, pix_ce, (k == 4));
      end
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
